prescaler_multi_tick: RTL
=========================

PRESCALER_MULTI_TICK -- requirements
Module: prescaler_multi_tick

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of each channel's counter and divisor.
REQ-003 SHALL have parameter DIV_RST, default 5999: divisor value every channel holds after reset.
REQ-004 SHALL have port sysclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_en, input, N_CH bits: per-channel count enable.
REQ-007 SHALL have port i_sync, input, 1 bit: one-cycle strobe that realigns all channels.
REQ-008 SHALL have port i_load, input, 1 bit: one-cycle divisor write strobe.
REQ-009 SHALL have port i_load_ch, input, $clog2(N_CH) bits (min 1): target channel of the write.
REQ-010 SHALL have port i_load_div, input, CNT_W bits: new terminal count.
REQ-011 SHALL have port o_tick, output, N_CH bits: one-cycle enable pulse per channel period.
REQ-012 SHALL have port o_clk, output, N_CH bits: 50% square wave per channel.

Function
REQ-013 Each channel SHALL hold a counter cnt and a divisor div, both CNT_W bits wide.
REQ-014 On an edge with en=1 and cnt < div, cnt SHALL increment by 1.
REQ-015 On an edge with en=1 and cnt >= div, the channel SHALL wrap: cnt <- 0, o_tick <- 1 for exactly that following cycle, and o_clk toggles.
REQ-016 Tick period SHALL be div+1 enabled cycles, and o_clk period SHALL be 2*(div+1) enabled cycles.
REQ-017 div=0 SHALL produce o_tick high continuously and o_clk toggling every cycle.
REQ-018 Maximum div (all ones) SHALL work with no overflow; the counter SHALL never exceed div.
REQ-019 When en=0, a channel SHALL hold cnt and o_clk, and SHALL drive o_tick 0.
REQ-020 i_load=1 with i_load_ch < N_CH SHALL write div of that channel and clear its cnt on the same edge, keep o_clk, and suppress o_tick for that edge.
REQ-021 i_load with i_load_ch >= N_CH SHALL be ignored entirely.
REQ-022 i_sync=1 SHALL clear every channel's cnt and o_clk to 0 and suppress every o_tick for that edge, regardless of en.
REQ-023 i_sync and i_load in the same cycle SHALL both take effect: the divisor is written and all channels are synchronised.
REQ-024 A new divisor SHALL govern counting from the edge after the write; there SHALL be no partial period at the old value.
REQ-025 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-026 i_rst_n=0 SHALL asynchronously set every cnt=0, div=DIV_RST, o_tick=0 and o_clk=0.
REQ-027 Reset asserted mid-period SHALL discard that period; counting resumes from 0 on the first enabled edge after i_rst_n rises.
REQ-028 All flops, including the divisor registers, SHALL be reset; no reliance on initial values.

Structure
REQ-029 Shared package prescaler_pkg SHALL hold the default CNT_W, DIV_RST and N_CH_MAX constants.
REQ-030 One sub-module prescaler_ch (one counter, one divisor, tick and clk flops) SHALL be instantiated N_CH times via generate.
REQ-031 The top level SHALL contain only load decode, sync fan-out and port packing.

Verification
REQ-032 Reset, then i_load ch0 div=3, en[0]=1 -> first o_tick[0] 4 cycles after the load, then every 4 cycles; o_clk[0] period 8.
REQ-033 div=0 on ch1 -> o_tick[1] constant 1 and o_clk[1] toggling every cycle; en[1] dropped -> o_tick[1]=0 and o_clk[1] frozen.
REQ-034 Channels at div=2 and div=5 running, pulse i_sync -> both o_clk=0 and cnt=0; next ticks at +3 and +6 cycles.
REQ-035 Load div=9 on ch2 mid-period (cnt=4) -> no tick on that edge; next tick 10 cycles later.
REQ-036 i_load_ch=N_CH -> no channel changes; i_rst_n pulsed low mid-count -> outputs 0 and div=5999 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prescaler_multi_tick_pkg.sv
// Shared defaults and helpers for the multi-channel prescaler.
// Holds no logic, so it adds no latency and takes no part in backpressure.
package prescaler_pkg;

   localparam int CNT_W_DEF   = 32;
   localparam int DIV_RST_DEF = 5999;
   localparam int N_CH_MAX    = 16;

   // A single channel still needs a one-bit select so the load port never collapses to zero width
   function automatic int lch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prescaler_multi_tick_if.sv
// Control and output bundle of the prescaler: enables, sync/load strobes, tick and clock outputs.
// Pure wiring with no latency; strobes are single-cycle and there is no backpressure.
interface prescaler_multi_tick_if import prescaler_pkg::*; #(
   parameter int N_CH  = 4,
   parameter int CNT_W = CNT_W_DEF
);
   localparam int LCH_W = lch_w(N_CH);

   logic [N_CH-1:0]  i_en;
   logic             i_sync;
   logic             i_load;
   logic [LCH_W-1:0] i_load_ch;
   logic [CNT_W-1:0] i_load_div;
   logic [N_CH-1:0]  o_tick;
   logic [N_CH-1:0]  o_clk;

   modport master (
      output i_en, i_sync, i_load, i_load_ch, i_load_div,
      input  o_tick, o_clk
   );

   modport slave (
      input  i_en, i_sync, i_load, i_load_ch, i_load_div,
      output o_tick, o_clk
   );

endinterface

// File: rtl/prescaler_multi_tick_ch.sv
// One divider channel: counter, divisor, registered tick pulse and half-rate square wave.
// Outputs change one edge after the inputs that cause them; never stalls, no backpressure.
module prescaler_ch import prescaler_pkg::*; #(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic             sysclk,
   input  logic             i_rst_n,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_div_i,
   output logic             tick_o,
   output logic             clk_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             clk_q, clk_d;

   // Wrap test uses >= so a shrunk divisor can never leave the counter stranded above it
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      clk_d  = clk_q;
      if (sync_i) begin
         cnt_d = '0;
         clk_d = 1'b0;
         if (load_i) begin
            div_d = load_div_i;
         end
      end else if (load_i) begin
         div_d = load_div_i;
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q >= div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = ~clk_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q  <= '0;
         div_q  <= CNT_W'(DIV_RST);
         tick_q <= 1'b0;
         clk_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         clk_q  <= clk_d;
      end
   end

   assign tick_o = tick_q;
   assign clk_o  = clk_q;

endmodule

// File: rtl/prescaler_multi_tick.sv
// N_CH independent tick/clock dividers sharing one sync strobe and one divisor write port.
// One-edge latency from strobe to outputs; all outputs come straight from channel flops, no backpressure.
module prescaler_multi_tick import prescaler_pkg::*; #(
   parameter int N_CH    = 4,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic                  sysclk,
   input  logic                  i_rst_n,
   prescaler_multi_tick_if.slave bus
);

   localparam int LCH_W = lch_w(N_CH);

   logic [N_CH-1:0] load_hit;
   logic [N_CH-1:0] tick_w;
   logic [N_CH-1:0] clk_w;

   // Equality decode: a select of N_CH or above matches no channel, so the write is dropped
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign load_hit[i] = bus.i_load && (bus.i_load_ch == LCH_W'(i));

      prescaler_ch #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_ch (
         .sysclk     (sysclk),
         .i_rst_n    (i_rst_n),
         .en_i       (bus.i_en[i]),
         .sync_i     (bus.i_sync),
         .load_i     (load_hit[i]),
         .load_div_i (bus.i_load_div),
         .tick_o     (tick_w[i]),
         .clk_o      (clk_w[i])
      );
   end

   assign bus.o_tick = tick_w;
   assign bus.o_clk  = clk_w;

endmodule
